// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem bus master: FSM state encoding, the
// read strobe value, default timeout constants and the board peripheral
// base bytes used by the address decoder.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // A command with all byte enables clear is a read.
  localparam logic [3:0] IOMEM_WSTRB_READ = 4'b0000;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] DEF_TIMEOUT_RDATA  = 32'hDEAD_BEEF;

  // Top address byte of each peripheral window on the board decoder.
  localparam logic [7:0] BASE_GPIO = 8'h03;
  localparam logic [7:0] BASE_LEDS = 8'h04;
  localparam logic [7:0] BASE_MMIO = 8'h06;

endpackage

// File: rtl/iomem_watchdog.sv
// Bus-cycle watchdog for the iomem master. Counts the cycles a transaction
// has spent on the bus and flags the cycle in which the LIMIT-th bus cycle
// is running, so the master can abandon it at the end of that cycle.
module iomem_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // cnt_q holds the number of bus cycles already completed, so the
  // LIMIT-th cycle is the one in which cnt_q equals LIMIT-1.
  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q, cnt_d;

  // Clear wins over enable so every transaction starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/iomem_bus_master.sv
// Single-outstanding initiator for the PicoSoC iomem bus. A command taken on
// the cmd port is driven onto the bus until the responder answers, and the
// sampled read data is then offered on the rsp port until consumed.
// Optional feature macro: IOMEM_MASTER_TIMEOUT_EN -- when defined, a bus
// access left unanswered for TIMEOUT_CYCLES cycles is aborted with
// rsp_err=1 and rsp_rdata=TIMEOUT_RDATA; otherwise the bus waits forever.
module iomem_bus_master
  import iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] TIMEOUT_RDATA  = DEF_TIMEOUT_RDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept;
  logic        bus_timeout;

  // cmd_ready_q is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept = cmd_valid && cmd_ready_q;

`ifdef IOMEM_MASTER_TIMEOUT_EN
  iomem_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (state_q == ST_BUS),
    .expired (bus_timeout)
  );
`else
  assign bus_timeout = 1'b0;
  // The cycle limit only matters when the watchdog is built in.
  logic unused_cfg;
  assign unused_cfg = ^16'(TIMEOUT_CYCLES);
`endif

  // Transaction sequencing: latch the command, wait for the responder (or
  // the watchdog), then hold the response until the consumer takes it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // A responder answer in the expiry cycle still counts as success.
        if (iomem_ready) begin
          rdata_d = iomem_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (bus_timeout) begin
          rdata_d = TIMEOUT_RDATA;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered ready: high exactly when the next state is IDLE.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // All outputs come straight from registers.
  assign cmd_ready   = cmd_ready_q;
  assign iomem_valid = (state_q == ST_BUS);
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign iomem_wstrb = wstrb_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;

endmodule
